gama_table_loader: RTL and testbench
====================================

// Module: gama_table_loader
// PURPOSE
// - Host-side writer for the gamma-correction lookup RAMs: fills the R, G and B tables through
//   their shared write port (wrdata / wraddress / write).
// - Source is a valid/ready word stream, or a built-in identity ramp (optional feature).
// - Sits between the control/command path and the gamma block.
// - The gamma block's wrclock input is tied to iCLK.
// PARAMETERS
// - DATA_WIDTH   10     pixel/table word width; each table holds 2**DATA_WIDTH entries
// - TIMEOUT_CYC  65535  max idle cycles without iDVAL during a stream load before abort
// PORTS
// - iCLK       in   1       single clock for all logic
// - iRST       in   1       reset, synchronous, active-high
// - iSTART     in   1       start pulse; sampled only in IDLE
// - iCH_MASK   in   3       channels to load: [0]=R, [1]=G, [2]=B
// - iMODE      in   1       0=stream, 1=identity ramp (honoured only with GAMA_IDENTITY_EN)
// - iDATA      in   DW      stream table word
// - iDVAL      in   1       iDATA valid
// - oREADY     out  1       loader accepts iDATA this cycle
// - wrdata     out  DW      table word to RAM
// - wraddress  out  DW+2    {channel code, index}; code 1=R, 2=G, 3=B, 0=no write
// - write      out  1       write strobe, mirrors (wraddress[DW+1:DW]!=0)
// - oBUSY      out  1       load in progress
// - oDONE      out  1       one-cycle pulse when a load completes
// - oERR       out  1       sticky timeout flag; cleared by the next accepted iSTART
// BEHAVIOUR
// - Clock and reset: one clock, iCLK. Reset iRST is synchronous, active-high.
// - Reset values:
//   - state = IDLE.
//   - All outputs 0; wraddress = 0.
//   - Index and timeout counters 0.
// - FSM states: IDLE -> LOAD -> (next channel | FIN) -> IDLE.
// - IDLE:
//   - iSTART=1 with a nonzero mask: clear oERR, select the lowest set channel (order R, G, B),
//     set index=0, go to LOAD.
//   - iSTART=1 with mask 0: oDONE pulses next cycle; no writes occur.
// - LOAD (stream mode):
//   - oREADY=1. A word is accepted on cycle N when iDVAL && oREADY.
//   - On cycle N+1: write=1, wrdata=iDATA, wraddress={code, index}.
//   - Latency is exactly one cycle; back-to-back accepts give one write per cycle.
// - Index wrap and channel advance:
//   - After the word at index 2**DW-1 is accepted, the index wraps to 0.
//   - The FSM then moves to the next set channel with no gap cycle.
//   - If no channel remains, the FSM goes to FIN and oREADY drops the same cycle.
// - FIN: oDONE=1 for one cycle, oBUSY=0, then IDLE.
// - oBUSY = 1 in LOAD; 0 otherwise.
// - RAM write-enable safety (hard rule):
//   - The RAM write-enable decodes from the wraddress top bits only.
//   - So wraddress[DW+1:DW] must be 0 on every cycle where write=0.
//   - Reset or abort forces them to 0 on the next edge.
// - Timeout:
//   - The counter increments on each LOAD cycle without an accept and clears on accept.
//   - When it reaches TIMEOUT_CYC: oERR=1, oREADY=0, go to IDLE, no oDONE.
//   - Partially written table contents are left as they are.
// - Ignored inputs: iSTART while busy is ignored; iCH_MASK and iMODE are latched at start.
// - Reset mid-load: takes effect on the next edge. The word being written that cycle is dropped.
// CONFIGURATION
// - Macro GAMA_IDENTITY_EN defined, iMODE=1:
//   - LOAD runs without handshake; oREADY=0 and iDVAL is ignored.
//   - One write per cycle with wrdata=index (identity curve).
//   - Takes 2**DW cycles per selected channel; the timeout is disabled.
// - Macro not defined: iMODE is ignored and every load is a stream load; no ramp logic is built.
// TESTING
// - Reset, then idle for 10 cycles -> all outputs 0; write=0 and wraddress=0 every cycle.
// - Mask=3'b001, 1024 back-to-back stream words = idx^10'h3FF:
//   - exactly 1024 writes with code 1, addr 0..1023, each one cycle after its accept.
//   - oDONE pulses once, one cycle after the last write.
// - Mask=3'b101, iDVAL toggling every other cycle:
//   - 1024 writes with code 1, then 1024 with code 3; no code 2 writes.
//   - the top address bits are 0 on every non-write cycle.
// - Mask=3'b010, TIMEOUT_CYC=16, stall after 5 words:
//   - 5 writes, then oERR=1 after 16 idle cycles and the FSM returns to IDLE with no oDONE.
//   - the next iSTART clears oERR.
// - iRST asserted at word 300 of an R load:
//   - next cycle all outputs 0, state IDLE.
//   - a fresh iSTART restarts from addr 0.
// - With GAMA_IDENTITY_EN, mask=3'b111, iMODE=1:
//   - 3072 consecutive writes with wrdata=addr, codes 1, 2, 3 in order.
//   - oDONE at cycle 3073 after start.

Source files
------------

// File: rtl/gama_table_loader.sv
// Writer for the gamma LUT RAMs: streams words (or an identity ramp when GAMA_IDENTITY_EN
// is defined) into the R/G/B tables through the shared {code, index} write port.
module gama_table_loader #(
  parameter int unsigned DATA_WIDTH  = 10,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iSTART,
  input  logic [2:0]              iCH_MASK,
  input  logic                    iMODE,
  input  logic [DATA_WIDTH-1:0]   iDATA,
  input  logic                    iDVAL,
  output logic                    oREADY,
  output logic [DATA_WIDTH-1:0]   wrdata,
  output logic [DATA_WIDTH+1:0]   wraddress,
  output logic                    write,
  output logic                    oBUSY,
  output logic                    oDONE,
  output logic                    oERR
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FIN} stateT;

  stateT          state;
  logic [1:0]     chanCode;
  logic [2:0]     chanLeft;
  logic [DW-1:0]  index;
  logic [TW-1:0]  idleCnt;
  logic           accept;
  logic [DW-1:0]  nextWord;

`ifdef GAMA_IDENTITY_EN
  logic           rampMode;
`else
  logic           modeUnused;
  assign modeUnused = iMODE;
`endif

  // Channel code of the lowest set mask bit, scanning R, G, B.
  function automatic logic [1:0] lowCode(input logic [2:0] m);
    if (m[0])      return 2'd1;
    else if (m[1]) return 2'd2;
    else if (m[2]) return 2'd3;
    else           return 2'd0;
  endfunction

  // A ramp load writes every LOAD cycle; a stream load only on handshake.
  always_comb begin
    accept   = (state == LOAD) && iDVAL && oREADY;
    nextWord = iDATA;
`ifdef GAMA_IDENTITY_EN
    if ((state == LOAD) && rampMode) begin
      accept   = 1'b1;
      nextWord = index;
    end
`endif
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      chanCode  <= 2'd0;
      chanLeft  <= 3'd0;
      index     <= '0;
      idleCnt   <= '0;
      oREADY    <= 1'b0;
      wrdata    <= '0;
      wraddress <= '0;
      write     <= 1'b0;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
      oERR      <= 1'b0;
`ifdef GAMA_IDENTITY_EN
      rampMode  <= 1'b0;
`endif
    end else begin
      // Write port idles with a zero code so the RAM enable stays off.
      write     <= 1'b0;
      wraddress <= '0;
      wrdata    <= '0;
      oDONE     <= 1'b0;
      case (state)
        IDLE: begin
          if (iSTART) begin
            if (iCH_MASK != 3'd0) begin
              oERR     <= 1'b0;
              chanCode <= lowCode(iCH_MASK);
              chanLeft <= iCH_MASK & (iCH_MASK - 3'd1);
              index    <= '0;
              idleCnt  <= '0;
              oBUSY    <= 1'b1;
              state    <= LOAD;
`ifdef GAMA_IDENTITY_EN
              rampMode <= iMODE;
              oREADY   <= ~iMODE;
`else
              oREADY   <= 1'b1;
`endif
            end else begin
              oDONE <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            write     <= 1'b1;
            wrdata    <= nextWord;
            wraddress <= {chanCode, index};
            idleCnt   <= '0;
            index     <= index + DW'(1);
            if (index == {DW{1'b1}}) begin
              if (chanLeft != 3'd0) begin
                chanCode <= lowCode(chanLeft);
                chanLeft <= chanLeft & (chanLeft - 3'd1);
              end else begin
                state  <= FIN;
                oREADY <= 1'b0;
                oBUSY  <= 1'b0;
              end
            end
          end else if (idleCnt == TW'(TIMEOUT_CYC - 1)) begin
            oERR    <= 1'b1;
            oREADY  <= 1'b0;
            oBUSY   <= 1'b0;
            idleCnt <= '0;
            state   <= IDLE;
          end else begin
            idleCnt <= idleCnt + TW'(1);
          end
        end
        FIN: begin
          oDONE <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gama_table_loader.sv
// Directed bench for gama_table_loader: scoreboard of expected RAM writes checked by a
// negedge monitor; covers the identity ramp when GAMA_IDENTITY_EN is defined.
module tb_gama_table_loader;

  localparam int unsigned DW = 10;
  localparam int unsigned TO = 16;

  logic          iCLK = 1'b0;
  logic          iRST, iSTART, iMODE, iDVAL;
  logic [2:0]    iCH_MASK;
  logic [DW-1:0] iDATA;
  logic          oREADY, write, oBUSY, oDONE, oERR;
  logic [DW-1:0] wrdata;
  logic [DW+1:0] wraddress;

  gama_table_loader #(.DATA_WIDTH(DW), .TIMEOUT_CYC(TO)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iCH_MASK(iCH_MASK), .iMODE(iMODE),
    .iDATA(iDATA), .iDVAL(iDVAL), .oREADY(oREADY), .wrdata(wrdata),
    .wraddress(wraddress), .write(write), .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int            cyc;
    logic [DW+1:0] addr;
    logic [DW-1:0] data;
  } expT;

  expT sb[$];
  int  cyc = 0;
  int  nChecks = 0, nPass = 0, nFail = 0;
  int  wrCnt = 0, doneCnt = 0, doneCyc = 0, lastWrCyc = 0;
  int  codeCnt [4] = '{0, 0, 0, 0};
  int  startEdge = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every write must match the oldest pending expectation, on its exact cycle.
  always @(negedge iCLK) begin
    expT e;
    check("we_decode", 32'(write), 32'(|wraddress[DW+1:DW]));
    if (oDONE === 1'b1) begin
      doneCnt++;
      doneCyc = cyc;
    end
    if (write === 1'b1) begin
      wrCnt++;
      codeCnt[wraddress[DW+1:DW]]++;
      lastWrCyc = cyc;
      check("sb_nonempty", 32'(sb.size() > 0), 32'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wr_addr", 32'(wraddress), 32'(e.addr));
        check("wr_data", 32'(wrdata), 32'(e.data));
        check("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic startLoad(input logic [2:0] mask, input logic mode);
    iSTART = 1'b1; iCH_MASK = mask; iMODE = mode;
    @(negedge iCLK);
    iSTART = 1'b0; iCH_MASK = 3'd0; iMODE = 1'b0;
    startEdge = cyc;
  endtask

  // Offer one word (optionally after a one-cycle gap); expectation logged at handshake.
  task automatic sendWord(input logic [1:0] code, input int idx, input logic [DW-1:0] data,
                          input bit gap);
    int waitCyc = 0;
    if (gap) begin
      iDVAL = 1'b0;
      @(negedge iCLK);
    end
    iDATA = data;
    iDVAL = 1'b1;
    while (oREADY !== 1'b1 && waitCyc < 50) begin
      @(negedge iCLK);
      waitCyc++;
    end
    if (waitCyc == 50) check("ready_wait", 32'(oREADY), 32'(1));
    sb.push_back('{cyc + 1, {code, DW'(idx)}, data});
    @(negedge iCLK);
  endtask

  task automatic pulseReset();
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, d0, c1, c2, c3, lastAcc, k;
    logic [DW-1:0] d;
    iRST = 1'b1; iSTART = 1'b0; iMODE = 1'b0; iDVAL = 1'b0; iCH_MASK = 3'd0; iDATA = '0;
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;

    // Idle after reset: everything quiet.
    for (int i = 0; i < 10; i++) begin
      check("reset_idle", 32'({oREADY, wrdata, wraddress, write, oBUSY, oDONE, oERR}), 32'(0));
      @(negedge iCLK);
    end

    // R only, back-to-back words idx ^ 3FF.
    w0 = wrCnt; d0 = doneCnt;
    startLoad(3'b001, 1'b0);
    check("busy_after_start", 32'(oBUSY), 32'(1));
    check("ready_after_start", 32'(oREADY), 32'(1));
    for (int i = 0; i < 1024; i++) sendWord(2'd1, i, DW'(i) ^ 10'h3FF, 1'b0);
    iDVAL = 1'b0;
    check("ready_drop_last", 32'(oREADY), 32'(0));
    check("busy_drop_last", 32'(oBUSY), 32'(0));
    repeat (3) @(negedge iCLK);
    check("r_write_count", 32'(wrCnt - w0), 32'(1024));
    check("r_done_count", 32'(doneCnt - d0), 32'(1));
    check("r_done_cycle", 32'(doneCyc), 32'(lastWrCyc + 1));
    check("r_sb_empty", 32'(sb.size()), 32'(0));

    // R then B, iDVAL every other cycle.
    w0 = wrCnt; d0 = doneCnt; c1 = codeCnt[1]; c2 = codeCnt[2]; c3 = codeCnt[3];
    startLoad(3'b101, 1'b0);
    for (int i = 0; i < 1024; i++) begin d = DW'($urandom); sendWord(2'd1, i, d, 1'b1); end
    for (int i = 0; i < 1024; i++) begin d = DW'($urandom); sendWord(2'd3, i, d, 1'b1); end
    iDVAL = 1'b0;
    repeat (3) @(negedge iCLK);
    check("rb_code1", 32'(codeCnt[1] - c1), 32'(1024));
    check("rb_code2", 32'(codeCnt[2] - c2), 32'(0));
    check("rb_code3", 32'(codeCnt[3] - c3), 32'(1024));
    check("rb_done_count", 32'(doneCnt - d0), 32'(1));
    check("rb_done_cycle", 32'(doneCyc), 32'(lastWrCyc + 1));

    // G, stall after 5 words until the timeout aborts.
    w0 = wrCnt; d0 = doneCnt;
    startLoad(3'b010, 1'b0);
    for (int i = 0; i < 5; i++) sendWord(2'd2, i, DW'(100 + i), 1'b0);
    iDVAL = 1'b0;
    lastAcc = cyc;
    k = 0;
    while (oERR !== 1'b1 && k < 40) begin
      @(negedge iCLK);
      k++;
    end
    check("to_err_cycle", 32'(cyc), 32'(lastAcc + 16));
    check("to_err_set", 32'(oERR), 32'(1));
    check("to_busy", 32'(oBUSY), 32'(0));
    check("to_ready", 32'(oREADY), 32'(0));
    repeat (4) @(negedge iCLK);
    check("to_err_sticky", 32'(oERR), 32'(1));
    check("to_write_count", 32'(wrCnt - w0), 32'(5));
    check("to_no_done", 32'(doneCnt - d0), 32'(0));
    startLoad(3'b010, 1'b0);
    check("to_err_cleared", 32'(oERR), 32'(0));
    check("to_restart_busy", 32'(oBUSY), 32'(1));
    pulseReset();

    // Reset while word 300 of an R load is offered.
    startLoad(3'b001, 1'b0);
    for (int i = 0; i < 300; i++) begin d = DW'($urandom); sendWord(2'd1, i, d, 1'b0); end
    iDATA = 10'h155; iDVAL = 1'b1; iRST = 1'b1;
    @(negedge iCLK);
    check("rst_outputs", 32'({oREADY, wrdata, wraddress, write, oBUSY, oDONE, oERR}), 32'(0));
    check("rst_sb_empty", 32'(sb.size()), 32'(0));
    iRST = 1'b0; iDVAL = 1'b0;
    @(negedge iCLK);
    check("rst_idle_busy", 32'(oBUSY), 32'(0));
    startLoad(3'b001, 1'b0);
    for (int i = 0; i < 4; i++) sendWord(2'd1, i, DW'(7 * i + 3), 1'b0);
    iDVAL = 1'b0;
    pulseReset();

`ifdef GAMA_IDENTITY_EN
    // Identity ramp over all three tables.
    w0 = wrCnt; d0 = doneCnt;
    startLoad(3'b111, 1'b1);
    for (int i = 0; i < 3072; i++)
      sb.push_back('{startEdge + 1 + i, {2'(i / 1024 + 1), DW'(i % 1024)}, DW'(i % 1024)});
    check("ramp_ready_low", 32'(oREADY), 32'(0));
    k = 0;
    while (doneCnt == d0 && k < 3200) begin
      @(negedge iCLK);
      k++;
    end
    check("ramp_done_cycle", 32'(doneCyc), 32'(startEdge + 3073));
    check("ramp_write_count", 32'(wrCnt - w0), 32'(3072));
    check("ramp_sb_empty", 32'(sb.size()), 32'(0));
`else
    // Without the ramp option iMODE=1 still runs a stream load.
    startLoad(3'b100, 1'b1);
    check("mode_ignored_ready", 32'(oREADY), 32'(1));
    sendWord(2'd3, 0, 10'h2A5, 1'b0);
    sendWord(2'd3, 1, 10'h05A, 1'b0);
    iDVAL = 1'b0;
    pulseReset();
`endif

    repeat (3) @(negedge iCLK);
    check("final_sb_empty", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
